split_arbiter: RTL and testbench
================================

SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 The block SHALL have no parameters; it arbitrates exactly two masters and one split-capable slave.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 m1_breq  input  1  master 1 bus request; held high for the whole transaction.
REQ-005 m2_breq  input  1  master 2 bus request; held high for the whole transaction.
REQ-006 s_split  input  1  one-cycle pulse from the slave: current transaction is split.
REQ-007 s_ready  input  1  level from the slave: split transaction may resume.
REQ-008 m1_bgrant  output  1  bus granted to master 1.
REQ-009 m2_bgrant  output  1  bus granted to master 2.
REQ-010 m1_split  output  1  master 1 has a pending split transaction.
REQ-011 m2_split  output  1  master 2 has a pending split transaction.
REQ-012 split_grant  output  1  current grant is a resumed split transaction.
REQ-013 msel  output  1  bus mux select: 0 = master 1, 1 = master 2; holds its last value when idle.
REQ-014 bus_busy  output  1  a grant is active.

Function
REQ-015 The block SHALL implement two states: IDLE and BUSY, plus registers owner, last_owner, split_pending, split_owner.
REQ-016 All outputs SHALL be registered; a grant SHALL appear one cycle after the request is sampled in IDLE.
REQ-017 Arbitration SHALL occur only in IDLE; at most one bgrant SHALL be high in any cycle.
REQ-018 IDLE priority SHALL be: (1) split_pending & s_ready -> grant split_owner with split_grant=1; (2) single eligible requester -> grant it; (3) both eligible -> grant the master not equal to last_owner.
REQ-019 While split_pending, the split owner's breq SHALL be ineligible for normal arbitration.
REQ-020 On a grant, the block SHALL set owner, last_owner and msel to the granted master, set bus_busy=1 and enter BUSY.
REQ-021 In BUSY, a low owner breq SHALL return the block to IDLE next cycle with bgrant, split_grant and bus_busy cleared; msel is unchanged.
REQ-022 In BUSY with split_grant=0, an s_split pulse SHALL set split_pending=1, set split_owner=owner, raise that master's mx_split, drop its bgrant and return the block to IDLE, all in the next cycle.
REQ-023 A resumed grant SHALL clear split_pending and the owner's mx_split in the same cycle that bgrant rises.
REQ-024 s_split SHALL be ignored in IDLE, during a resumed grant (split_grant=1), and while split_pending=1.
REQ-025 s_ready SHALL be ignored when split_pending=0 and while BUSY; a resume waits for IDLE.
REQ-026 owner breq low in the same cycle as s_split SHALL be treated as release: no split is recorded.

Reset
REQ-027 rst SHALL immediately force IDLE; all outputs 0; split_pending=0; split_owner=0; owner=0; last_owner=master 2, so master 1 wins the first tie.
REQ-028 Reset asserted mid-transaction or with a split pending SHALL discard that state with no grant or split output surviving.
REQ-029 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge sampling a request.

Verification
REQ-030 Reset, then m1_breq=m2_breq=1 -> next cycle m1_bgrant=1, msel=0; drop m1_breq -> one IDLE cycle -> m2_bgrant=1, msel=1.
REQ-031 Both breq held high continuously, each owner releasing after 3 cycles -> grants alternate M1, M2, M1, M2 with one idle cycle between each.
REQ-032 M1 granted, s_split pulse -> next cycle m1_bgrant=0, m1_split=1; m2_breq=1 -> m2 granted; s_ready=1 during M2 ownership -> no change; M2 releases -> m1_bgrant=1, split_grant=1, m1_split=0.
REQ-033 split pending for M1, s_ready=1 and m2_breq=1 in the same IDLE cycle -> M1 resumed, M2 waits; s_split during the resumed grant -> ignored.
REQ-034 s_split pulse in IDLE, and s_split coincident with owner breq low -> no mx_split raised, state IDLE.
REQ-035 rst pulsed while M2 is granted and M1 split is pending -> all outputs 0 immediately; after release m1_breq=1 -> m1_bgrant=1, split_grant=0.

Source files
------------

// File: rtl/split_arbiter.sv
// Two-master bus arbiter in front of one split-capable slave.
// Alternating tie-break, split parking and resume-first arbitration; every output is registered.
module split_arbiter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic m1_breq_i,
    input  logic m2_breq_i,
    input  logic s_split_i,
    input  logic s_ready_i,
    output logic m1_bgrant_o,
    output logic m2_bgrant_o,
    output logic m1_split_o,
    output logic m2_split_o,
    output logic split_grant_o,
    output logic msel_o,
    output logic bus_busy_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    // Master encoding used by owner/last_owner/split_owner/msel: 0 = master 1, 1 = master 2.
    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_owner_q, last_owner_d;
    logic   split_pending_q, split_pending_d;
    logic   split_owner_q, split_owner_d;
    logic   m1_bgrant_q, m1_bgrant_d;
    logic   m2_bgrant_q, m2_bgrant_d;
    logic   m1_split_q, m1_split_d;
    logic   m2_split_q, m2_split_d;
    logic   split_grant_q, split_grant_d;
    logic   msel_q, msel_d;
    logic   bus_busy_q, bus_busy_d;

    logic owner_breq;
    logic m1_elig;
    logic m2_elig;
    logic resume;
    logic grant_valid;
    logic grant_who;
    logic split_take;

    // A master with a parked split may only come back through the resume path.
    assign m1_elig     = m1_breq_i & ~(split_pending_q & (split_owner_q == M1));
    assign m2_elig     = m2_breq_i & ~(split_pending_q & (split_owner_q == M2));
    assign resume      = split_pending_q & s_ready_i;
    assign grant_valid = resume | m1_elig | m2_elig;

    always_comb begin
        grant_who = M1;
        if (resume) begin
            grant_who = split_owner_q;
        end else if (m1_elig && m2_elig) begin
            grant_who = ~last_owner_q;
        end else if (m2_elig) begin
            grant_who = M2;
        end
    end

    assign owner_breq = (owner_q == M2) ? m2_breq_i : m1_breq_i;

    // A release in the same cycle as s_split wins; resumed grants cannot be split again.
    assign split_take = s_split_i & owner_breq & ~split_grant_q & ~split_pending_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            owner_q         <= M1;
            last_owner_q    <= M2;
            split_pending_q <= 1'b0;
            split_owner_q   <= M1;
            m1_bgrant_q     <= 1'b0;
            m2_bgrant_q     <= 1'b0;
            m1_split_q      <= 1'b0;
            m2_split_q      <= 1'b0;
            split_grant_q   <= 1'b0;
            msel_q          <= 1'b0;
            bus_busy_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            split_pending_q <= split_pending_d;
            split_owner_q   <= split_owner_d;
            m1_bgrant_q     <= m1_bgrant_d;
            m2_bgrant_q     <= m2_bgrant_d;
            m1_split_q      <= m1_split_d;
            m2_split_q      <= m2_split_d;
            split_grant_q   <= split_grant_d;
            msel_q          <= msel_d;
            bus_busy_q      <= bus_busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!owner_breq || split_take) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        split_pending_d = split_pending_q;
        split_owner_d   = split_owner_q;
        m1_bgrant_d     = m1_bgrant_q;
        m2_bgrant_d     = m2_bgrant_q;
        m1_split_d      = m1_split_q;
        m2_split_d      = m2_split_q;
        split_grant_d   = split_grant_q;
        msel_d          = msel_q;
        bus_busy_d      = bus_busy_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    owner_d       = grant_who;
                    last_owner_d  = grant_who;
                    msel_d        = grant_who;
                    bus_busy_d    = 1'b1;
                    m1_bgrant_d   = (grant_who == M1);
                    m2_bgrant_d   = (grant_who == M2);
                    split_grant_d = resume;
                    if (resume) begin
                        split_pending_d = 1'b0;
                        if (split_owner_q == M1) begin
                            m1_split_d = 1'b0;
                        end else begin
                            m2_split_d = 1'b0;
                        end
                    end
                end
            end
            StBusy: begin
                if (!owner_breq) begin
                    m1_bgrant_d   = 1'b0;
                    m2_bgrant_d   = 1'b0;
                    split_grant_d = 1'b0;
                    bus_busy_d    = 1'b0;
                end else if (split_take) begin
                    split_pending_d = 1'b1;
                    split_owner_d   = owner_q;
                    m1_bgrant_d     = 1'b0;
                    m2_bgrant_d     = 1'b0;
                    bus_busy_d      = 1'b0;
                    if (owner_q == M1) begin
                        m1_split_d = 1'b1;
                    end else begin
                        m2_split_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign m1_bgrant_o   = m1_bgrant_q;
    assign m2_bgrant_o   = m2_bgrant_q;
    assign m1_split_o    = m1_split_q;
    assign m2_split_o    = m2_split_q;
    assign split_grant_o = split_grant_q;
    assign msel_o        = msel_q;
    assign bus_busy_o    = bus_busy_q;

endmodule

// File: tb/tb_split_arbiter.sv
// Scoreboard bench for split_arbiter: expected output vectors are queued as stimulus is
// driven and popped one cycle later, after the edge that produces them.
module tb_split_arbiter;

    logic clk;
    logic rst;
    logic m1_breq, m2_breq, s_split, s_ready;
    logic m1_bgrant, m2_bgrant, m1_split, m2_split, split_grant, msel, bus_busy;
    logic [6:0] obs;

    typedef struct {
        string      name;
        logic [6:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    split_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m1_breq_i    (m1_breq),
        .m2_breq_i    (m2_breq),
        .s_split_i    (s_split),
        .s_ready_i    (s_ready),
        .m1_bgrant_o  (m1_bgrant),
        .m2_bgrant_o  (m2_bgrant),
        .m1_split_o   (m1_split),
        .m2_split_o   (m2_split),
        .split_grant_o(split_grant),
        .msel_o       (msel),
        .bus_busy_o   (bus_busy)
    );

    // Observed vector: {m1_bgrant, m2_bgrant, m1_split, m2_split, split_grant, msel, bus_busy}
    assign obs = {m1_bgrant, m2_bgrant, m1_split, m2_split, split_grant, msel, bus_busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Inputs packed as {m1_breq, m2_breq, s_split, s_ready}
    task automatic drive(input logic [3:0] in);
        {m1_breq, m2_breq, s_split, s_ready} = in;
    endtask

    task automatic push_exp(input string name, input logic [6:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        drive(4'b1100);
        for (int i = 0; i < 2; i++) begin
            push_exp($sformatf("reset_hold_%0d", i), 7'b0000000);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
        drive(4'b0000);
        rst = 1'b0;
        push_exp("reset_idle", 7'b0000000);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
    endtask

    task automatic test_basic();
        logic [3:0] stim [6];
        logic [6:0] expv [6];
        exp_t e;
        stim = '{4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        expv = '{7'b1000001, 7'b1000001, 7'b0000000, 7'b0100011, 7'b0000010, 7'b0000010};
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            push_exp($sformatf("basic_%0d", i), expv[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_alternate();
        exp_t e;
        logic who;
        who = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (c < 3) begin
                    drive(4'b1100);
                    push_exp($sformatf("alt_%0d_grant_%0d", k, c),
                             who ? 7'b0100011 : 7'b1000001);
                end else begin
                    drive(who ? 4'b1000 : 4'b0100);
                    push_exp($sformatf("alt_%0d_release", k), {5'b00000, who, 1'b0});
                end
                @(posedge clk); #1;
                e = sb_q.pop_front();
                n_cmp++;
                if (obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
                end
            end
            who = ~who;
        end
        drive(4'b0000);
        push_exp("alt_idle", 7'b0000010);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
    endtask

    task automatic test_split();
        logic [3:0] stim [8];
        logic [6:0] expv [8];
        exp_t e;
        stim = '{4'b1000, 4'b1010, 4'b1100, 4'b1101, 4'b1001, 4'b1001, 4'b1000, 4'b0000};
        expv = '{7'b1000001, 7'b0010000, 7'b0110011, 7'b0110011,
                 7'b0010010, 7'b1000101, 7'b1000101, 7'b0000000};
        for (int i = 0; i < 8; i++) begin
            drive(stim[i]);
            push_exp($sformatf("split_%0d", i), expv[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_resume_priority();
        logic [3:0] stim [8];
        logic [6:0] expv [8];
        exp_t e;
        stim = '{4'b1000, 4'b1010, 4'b1101, 4'b1110, 4'b1100, 4'b0100, 4'b0100, 4'b0000};
        expv = '{7'b1000001, 7'b0010000, 7'b1000101, 7'b1000101,
                 7'b1000101, 7'b0000000, 7'b0100011, 7'b0000010};
        for (int i = 0; i < 8; i++) begin
            drive(stim[i]);
            push_exp($sformatf("resume_%0d", i), expv[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_split_ignored();
        logic [3:0] stim [6];
        logic [6:0] expv [6];
        exp_t e;
        stim = '{4'b0010, 4'b0001, 4'b1000, 4'b0010, 4'b0000, 4'b0001};
        expv = '{7'b0000010, 7'b0000010, 7'b1000001, 7'b0000000, 7'b0000000, 7'b0000000};
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            push_exp($sformatf("ignore_%0d", i), expv[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] stim [3];
        logic [6:0] expv [3];
        exp_t e;
        stim = '{4'b1000, 4'b1010, 4'b1100};
        expv = '{7'b1000001, 7'b0010000, 7'b0110011};
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            push_exp($sformatf("rstmid_setup_%0d", i), expv[i]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
        // Asynchronous assertion between edges must clear outputs at once.
        #1 rst = 1'b1;
        push_exp("rstmid_async", 7'b0000000);
        #1;
        e = sb_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
        push_exp("rstmid_hold", 7'b0000000);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
        rst = 1'b0;
        drive(4'b1000);
        push_exp("rstmid_m1_grant", 7'b1000001);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
        drive(4'b0000);
        push_exp("rstmid_release", 7'b0000000);
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_cmp++;
        if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(4'b0000);
        test_reset();
        test_basic();
        test_alternate();
        test_split();
        test_resume_priority();
        test_split_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
